// File: rtl/ram_write_queue_pkg.sv
// rtl/ram_write_queue_pkg.sv - shared widths for the RAM posted-write queue
package ram_write_queue_pkg;
`include "RamDefs.v"
   localparam int RAM_DATA_W   = `RAM_DATA_W;
   localparam int RAM_ADDR_W   = `RAM_ADDR_W;
   localparam int RAM_WQ_DEPTH = `RAM_WQ_DEPTH;
endpackage

// File: rtl/ram_write_queue_if.sv
// rtl/ram_write_queue_if.sv - write request, RAM store and read-forward signals
interface ram_write_queue_if
   import ram_write_queue_pkg::*;
#(
   parameter int DATA_W = RAM_DATA_W,
   parameter int ADDR_W = RAM_ADDR_W
);
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_ad;
   logic [DATA_W-1:0] in_x;
   logic              drain_en;
   logic              ram_st;
   logic [ADDR_W-1:0] ram_ad;
   logic [DATA_W-1:0] ram_x;
   logic [DATA_W-1:0] ram_y;
   logic [ADDR_W-1:0] rd_ad;
   logic [DATA_W-1:0] rd_y;
   logic              busy;

   modport master (
      output in_valid, in_ad, in_x, drain_en, ram_y, rd_ad,
      input  in_ready, ram_st, ram_ad, ram_x, rd_y, busy
   );

   modport slave (
      input  in_valid, in_ad, in_x, drain_en, ram_y, rd_ad,
      output in_ready, ram_st, ram_ad, ram_x, rd_y, busy
   );
endinterface

// File: rtl/RamDefs.v
// rtl/RamDefs.v - shared RAM geometry defines for the RAM and its write queue
`ifndef RAM_DEFS_V
`define RAM_DEFS_V
`define RAM_DATA_W 16
`define RAM_ADDR_W 1
`define RAM_WQ_DEPTH 4
`endif

// File: rtl/ram_wq_storage.sv
// rtl/ram_wq_storage.sv - queue entry array with per-entry valid bits
module ram_wq_storage #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 1,
   parameter int DEPTH  = 4,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic                               cl,
   input  logic                               rst,
   input  logic                               wr_en,
   input  logic [PW-1:0]                      wr_idx,
   input  logic [ADDR_W-1:0]                  wr_ad,
   input  logic [DATA_W-1:0]                  wr_x,
   input  logic                               pop_en,
   input  logic [PW-1:0]                      pop_idx,
   output logic [DEPTH-1:0][ADDR_W-1:0]       ent_ad,
   output logic [DEPTH-1:0][DATA_W-1:0]       ent_x,
   output logic [DEPTH-1:0]                   ent_vld
);
   // Entry payload carries no reset; only the valid bits define occupancy.
   always_ff @(posedge cl) begin
      if (wr_en) begin
         ent_ad[wr_idx] <= wr_ad;
         ent_x[wr_idx]  <= wr_x;
      end
   end

   // Push and pop never target the same slot: a full queue refuses pushes.
   always_ff @(posedge cl) begin
      if (rst) begin
         ent_vld <= '0;
      end else begin
         if (pop_en) ent_vld[pop_idx] <= 1'b0;
         if (wr_en)  ent_vld[wr_idx]  <= 1'b1;
      end
   end
endmodule

// File: rtl/ram_write_queue.sv
// rtl/ram_write_queue.sv - posted-write FIFO in front of the RAM with read forwarding
module ram_write_queue
   import ram_write_queue_pkg::*;
#(
   parameter int DATA_W = RAM_DATA_W,
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DEPTH  = RAM_WQ_DEPTH
) (
   input logic               cl,
   input logic               rst,
   ram_write_queue_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [PW-1:0]                 rd_ptr;
   logic [PW-1:0]                 wr_ptr;
   logic [PW:0]                   count;
   logic                          push;
   logic                          pop;
   logic [DEPTH-1:0][ADDR_W-1:0]  ent_ad;
   logic [DEPTH-1:0][DATA_W-1:0]  ent_x;
   logic [DEPTH-1:0]              ent_vld;
   logic [PW-1:0]                 idx;
   logic                          hit;

   assign bus.in_ready = (count != FULL);
   assign bus.busy     = (count != '0);
   assign push         = bus.in_valid && bus.in_ready;
   assign pop          = (count != '0) && bus.drain_en;

   // When not storing, the RAM address follows rd_ad so ram_y serves reads.
   assign bus.ram_st = pop;
   assign bus.ram_ad = pop ? ent_ad[rd_ptr] : bus.rd_ad;
   assign bus.ram_x  = ent_x[rd_ptr];

   always_ff @(posedge cl) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Youngest match wins: walk backward from the most recent push.
   always_comb begin
      bus.rd_y = bus.ram_y;
      hit      = 1'b0;
      idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = wr_ptr - PW'(k + 1);
         if (!hit && ent_vld[idx] && (ent_ad[idx] == bus.rd_ad)) begin
            hit      = 1'b1;
            bus.rd_y = ent_x[idx];
         end
      end
   end

   ram_wq_storage #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_storage (
      .cl      (cl),
      .rst     (rst),
      .wr_en   (push),
      .wr_idx  (wr_ptr),
      .wr_ad   (bus.in_ad),
      .wr_x    (bus.in_x),
      .pop_en  (pop),
      .pop_idx (rd_ptr),
      .ent_ad  (ent_ad),
      .ent_x   (ent_x),
      .ent_vld (ent_vld)
   );
endmodule
